// File: rtl/cla_slice_sequencer.sv
// Multi-cycle wide adder that time-shares one external SLICE-bit CLA slice.
// Chunks are fed LSB first, and the slice carry-out is registered as the
// carry-in for the next chunk.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, a, b, cin     request and operands, captured when accepted in IDLE
//   busy, done           busy in RUN/DONE; done is a one-cycle result-valid pulse
//   sum, cout, overflow  assembled result, held until the next accepted start
//   slice_a/b/cin        chunk fed to the external slice (0 outside RUN)
//   slice_s, slice_cout  combinational result returned by the slice
module cla_slice_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_s,
  input  logic             slice_cout
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              carry;
  logic [IDXW-1:0]   idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        S_RUN: begin
          sum[idx*SLICE +: SLICE] <= slice_s;
          carry <= slice_cout;
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            cout <= slice_cout;
            // Top chunk's sum MSB is the result sign bit
            overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (slice_s[SLICE-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  // Slice feed comes only from registered state; forced to zero outside RUN
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == S_RUN) begin
      slice_a   = a_reg[idx*SLICE +: SLICE];
      slice_b   = b_reg[idx*SLICE +: SLICE];
      slice_cin = carry;
    end
  end

endmodule
